// File: rtl/reg_status_file_pkg.sv
// Shared types and constants for the architectural register / rename status file.
package reg_status_file_pkg;

  localparam int REG_W  = 5;   // architectural register index width
  localparam int DATA_W = 32;  // register value width
  localparam int TAG_NONE = 0; // ROB never issues tag 0, so it marks "no producer"

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  // A write/rename only touches state when strobed and not aimed at x0.
  function automatic logic rd_live(input logic vld, input reg_idx_t rd);
    return vld && (rd != '0);
  endfunction

endpackage

// File: rtl/reg_query_port.sv
// One dispatch operand lookup: raw state read plus optional commit bypass.
// Optional feature: REG_COMMIT_BYPASS_EN forwards a same-cycle commit to the query.
module reg_query_port
  import reg_status_file_pkg::*;
#(
  parameter int REG_NUM   = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic [REG_W-1:0]                     idx_i,
  input  logic [REG_NUM-1:0]                   busy_arr_i,
  input  logic [REG_NUM-1:0][TAG_WIDTH-1:0]    tag_arr_i,
  input  logic [REG_NUM-1:0][DATA_W-1:0]       val_arr_i,
  input  logic                                 commit_valid_i,
  input  logic [REG_W-1:0]                     commit_rd_i,
  input  logic [DATA_W-1:0]                    commit_res_i,
  input  logic [TAG_WIDTH-1:0]                 commit_dep_i,
  output logic                                 busy_o,
  output logic [TAG_WIDTH-1:0]                 tag_o,
  output logic [DATA_W-1:0]                    val_o
);

  logic                 raw_busy;
  logic [TAG_WIDTH-1:0] raw_tag;
  logic [DATA_W-1:0]    raw_val;
  logic                 hit;

  assign raw_busy = busy_arr_i[idx_i];
  assign raw_tag  = tag_arr_i[idx_i];
  assign raw_val  = val_arr_i[idx_i];

`ifdef REG_COMMIT_BYPASS_EN
  // Commit resolving the current producer of this operand this very cycle.
  assign hit = commit_valid_i && (commit_rd_i == idx_i) && (idx_i != '0)
            && raw_busy && (raw_tag == commit_dep_i);
`else
  logic unused_commit;
  assign unused_commit = ^{commit_valid_i, commit_rd_i, commit_res_i, commit_dep_i};
  assign hit = 1'b0;
`endif

  // x0 is forced to zero even though its state is never written.
  always_comb begin
    busy_o = 1'b0;
    tag_o  = '0;
    val_o  = '0;
    if (idx_i != '0) begin
      if (hit) begin
        val_o = commit_res_i;
      end else begin
        busy_o = raw_busy;
        tag_o  = raw_busy ? raw_tag : '0;
        val_o  = raw_val;
      end
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Commits write values; renames claim registers; flush drops all rename state.
// Optional feature: REG_COMMIT_BYPASS_EN enables commit-to-query forwarding.
module reg_status_file
  import reg_status_file_pkg::*;
#(
  parameter int REG_NUM   = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 rename_valid,
  input  logic [REG_W-1:0]     rename_rd,
  input  logic [TAG_WIDTH-1:0] rename_tag,
  input  logic                 commit_valid,
  input  logic [REG_W-1:0]     commit_rd,
  input  logic [DATA_W-1:0]    commit_res,
  input  logic [TAG_WIDTH-1:0] commit_dependency,
  input  logic [REG_W-1:0]     rs1_idx,
  input  logic [REG_W-1:0]     rs2_idx,
  output logic                 rs1_busy,
  output logic [TAG_WIDTH-1:0] rs1_tag,
  output logic [DATA_W-1:0]    rs1_val,
  output logic                 rs2_busy,
  output logic [TAG_WIDTH-1:0] rs2_tag,
  output logic [DATA_W-1:0]    rs2_val
);

  logic [REG_NUM-1:0]                busy_q, busy_d;
  logic [REG_NUM-1:0][TAG_WIDTH-1:0] tag_q,  tag_d;
  logic [REG_NUM-1:0][DATA_W-1:0]    val_q,  val_d;

  logic commit_live, rename_live, commit_owns;

  assign commit_live = rd_live(commit_valid, commit_rd);
  assign rename_live = rd_live(rename_valid, rename_rd);
  // Commit frees the register only if it is still the latest renamer and
  // no younger instruction claims the register this same cycle.
  assign commit_owns = commit_live && (tag_q[commit_rd] == commit_dependency)
                    && !(rename_live && (rename_rd == commit_rd));

  // Next-state: commit value always lands; rename beats commit; flush beats both.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_live) val_d[commit_rd] = commit_res;
    if (flush) begin
      busy_d = '0;
      tag_d  = '0;
    end else begin
      if (commit_owns) begin
        busy_d[commit_rd] = 1'b0;
        tag_d[commit_rd]  = '0;
      end
      if (rename_live) begin
        busy_d[rename_rd] = 1'b1;
        tag_d[rename_rd]  = rename_tag;
      end
    end
  end

  // State registers; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else if (rdy) begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  reg_query_port #(.REG_NUM(REG_NUM), .TAG_WIDTH(TAG_WIDTH)) u_q1 (
    .idx_i(rs1_idx), .busy_arr_i(busy_q), .tag_arr_i(tag_q), .val_arr_i(val_q),
    .commit_valid_i(commit_valid), .commit_rd_i(commit_rd),
    .commit_res_i(commit_res), .commit_dep_i(commit_dependency),
    .busy_o(rs1_busy), .tag_o(rs1_tag), .val_o(rs1_val)
  );

  reg_query_port #(.REG_NUM(REG_NUM), .TAG_WIDTH(TAG_WIDTH)) u_q2 (
    .idx_i(rs2_idx), .busy_arr_i(busy_q), .tag_arr_i(tag_q), .val_arr_i(val_q),
    .commit_valid_i(commit_valid), .commit_rd_i(commit_rd),
    .commit_res_i(commit_res), .commit_dep_i(commit_dependency),
    .busy_o(rs2_busy), .tag_o(rs2_tag), .val_o(rs2_val)
  );

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: rename/commit/flush/bypass/x0 scenarios.
module tb_reg_status_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        rename_valid;
  logic [4:0]  rename_rd;
  logic [4:0]  rename_tag;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_res;
  logic [4:0]  commit_dependency;
  logic [4:0]  rs1_idx, rs2_idx;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rs1_tag, rs2_tag;
  logic [31:0] rs1_val, rs2_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_status_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rename_valid(rename_valid), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_res(commit_res),
    .commit_dependency(commit_dependency),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_val(rs1_val),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_val(rs2_val)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; rename_valid = 0; rename_rd = 0; rename_tag = 0;
    commit_valid = 0; commit_rd = 0; commit_res = 0; commit_dependency = 0;
  endtask

  // Advance past one rising edge, then drop all strobes.
  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] t);
    rename_valid = 1; rename_rd = rd; rename_tag = t;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] t, input logic [31:0] r);
    commit_valid = 1; commit_rd = rd; commit_dependency = t; commit_res = r;
  endtask

  task automatic chk1(input string nm, input logic b, input logic [4:0] t, input logic [31:0] v);
    #1;
    check({nm, ".busy"}, {31'd0, rs1_busy}, {31'd0, b});
    check({nm, ".tag"},  {27'd0, rs1_tag},  {27'd0, t});
    check({nm, ".val"},  rs1_val, v);
  endtask

  task automatic chk2(input string nm, input logic b, input logic [4:0] t, input logic [31:0] v);
    #1;
    check({nm, ".busy"}, {31'd0, rs2_busy}, {31'd0, b});
    check({nm, ".tag"},  {27'd0, rs2_tag},  {27'd0, t});
    check({nm, ".val"},  rs2_val, v);
  endtask

  initial begin
    rst = 0; rdy = 1; idle(); rs1_idx = 5; rs2_idx = 0;
    #3;
    chk1("reset", 0, 0, 0);
    #4 rst = 1;
    step();

    // Reset mid-run clears a live rename asynchronously.
    rename(5, 3); step();
    chk1("ren_x5_pre_rst", 1, 3, 0);
    #2 rst = 0;
    chk1("async_rst", 0, 0, 0);
    rst = 1;
    step();

    // Plain rename then matching commit.
    rename(5, 3); step();
    chk1("ren_x5", 1, 3, 0);
    commit(5, 3, 32'h1234); step();
    chk1("com_x5", 0, 0, 32'h1234);

    // Stale commit leaves the younger renamer in place.
    rs1_idx = 7;
    rename(7, 2); step();
    rename(7, 4); step();
    commit(7, 2, 32'hAA); step();
    chk1("stale_x7", 1, 4, 32'hAA);
    commit(7, 4, 32'hBB); step();
    chk1("final_x7", 0, 0, 32'hBB);

    // Same-cycle commit and rename of one register: rename owns status.
    rs1_idx = 9;
    rename(9, 6); step();
    commit(9, 6, 32'h55); rename(9, 8); step();
    chk1("same_x9", 1, 8, 32'h55);

    // Flush with concurrent commit and rename.
    rename(3, 1); step();
    rename(4, 2); step();
    flush = 1; commit(3, 1, 32'h77); rename(6, 5); step();
    rs1_idx = 3; rs2_idx = 4;
    chk1("flush_x3", 0, 0, 32'h77);
    chk2("flush_x4", 0, 0, 0);
    rs1_idx = 6; rs2_idx = 9;
    chk1("flush_x6", 0, 0, 0);
    chk2("flush_x9", 0, 0, 32'h55);

    // rdy low freezes state.
    rdy = 0; rename(11, 7); commit(5, 0, 32'hFFFF); step();
    rdy = 1;
    rs1_idx = 11; rs2_idx = 5;
    chk1("hold_x11", 0, 0, 0);
    chk2("hold_x5", 0, 0, 32'h1234);

    // Same-cycle commit seen by a query.
    rs2_idx = 10;
    rename(10, 9); step();
    commit(10, 9, 32'hDEAD);
`ifdef REG_COMMIT_BYPASS_EN
    chk2("byp_x10", 0, 0, 32'hDEAD);
`else
    chk2("nobyp_x10", 1, 9, 0);
`endif
    step();
    chk2("after_x10", 0, 0, 32'hDEAD);

    // x0 ignores writes and renames, even in the cycle they are presented.
    rs1_idx = 0;
    commit(0, 0, 32'hFFFF_FFFF); rename(0, 3);
    chk1("x0_same", 0, 0, 0);
    step();
    chk1("x0_after", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus per-register rename status; the receiving end of the ROB commit port and the producer of operand status for dispatch.
- Dispatch queries it: for each source it gets a committed value, or the ROB tag of the producing instruction that is still in flight.
- On commit it writes the result and clears the register's busy bit only when the committing tag is still the latest renamer.
- On mispredict flush it discards all rename state and keeps the committed values.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired to zero.
- TAG_WIDTH, 5, ROB tag width; tag 0 means "no producer", because the ROB never issues tag 0.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global enable; when low, all state holds.
- flush  input  1  ROB wrong_commit; clears all rename state.
- rename_valid  input  1  dispatch is issuing an instruction that writes rename_rd.
- rename_rd  input  5  destination register of the dispatched instruction.
- rename_tag  input  TAG_WIDTH  ROB slot allocated to that instruction.
- commit_valid  input  1  ROB commit strobe.
- commit_rd  input  5  committed destination register.
- commit_res  input  32  committed value.
- commit_dependency  input  TAG_WIDTH  ROB tag of the committing entry.
- rs1_idx  input  5  source-1 query index.
- rs2_idx  input  5  source-2 query index.
- rs1_busy  output  1  source 1 awaits an in-flight producer.
- rs1_tag  output  TAG_WIDTH  producer tag when busy, else 0.
- rs1_val  output  32  committed value; valid when not busy.
- rs2_busy, rs2_tag, rs2_val  output  1/TAG_WIDTH/32  same for source 2.

Behaviour:
- State: val[REG_NUM] (32b), busy[REG_NUM], tag[REG_NUM].
- Reset (rst low, asynchronous): all val/busy/tag = 0. Query outputs are combinational and therefore read 0/0/0 during reset.
- rdy low: no state change. Queries stay live.
- Commit (rdy, commit_valid, commit_rd != 0):
  - val[commit_rd] <= commit_res.
  - If tag[commit_rd] == commit_dependency and no rename of commit_rd occurs this cycle: busy <= 0 and tag <= 0.
  - Otherwise busy and tag are untouched, because a younger writer owns the register.
- Rename (rdy, rename_valid, rename_rd != 0, flush low): busy[rename_rd] <= 1, tag[rename_rd] <= rename_tag.
- Rename and commit to the same rd in the same cycle: the value is written, and the rename wins for busy/tag.
- Flush (rdy, flush high): every busy and tag is cleared.
  - A commit in the same cycle is still written to val, since commit and wrong_commit are issued together for the same valid instruction.
  - A rename in the same cycle is dropped.
- x0: writes and renames are ignored. A query of x0 always returns busy=0, tag=0, val=0.
- Query (combinational, per port):
  - Default: busy = busy[idx], tag = busy ? tag[idx] : 0, val = val[idx].
  - Bypass (see Optional Feature): if commit_valid, commit_rd == idx != 0, busy[idx], and tag[idx] == commit_dependency, then return busy=0, tag=0, val=commit_res.
- The same-cycle rename is NOT visible to queries. Dispatch resolves intra-bundle dependencies itself.
- No latency beyond one edge: a committed or renamed state is visible on the next cycle.

Optional Feature:
- Macro REG_COMMIT_BYPASS_EN.
- Defined: the commit-to-query bypass above is active, so a consumer dispatched in the commit cycle sees the value immediately.
- Undefined: queries read raw state only. A consumer dispatched in the commit cycle sees busy=1 with the old tag; the ROB's ready/res lookup serves it.

Decomposition:
- const_def.v adds:
  - REG_RANGE [4:0].
  - TAG_RANGE [TAG_WIDTH-1:0].
  - REG_ARR [0:31].
  - TAG_NONE = 0.
- One sub-module, reg_query_port, instantiated twice. It takes idx plus a view of the state arrays and the commit bus, and produces busy/tag/val including the bypass logic.

Test Plan:
- Reset mid-run: rename x5 (tag 3), then pulse rst low asynchronously between edges → rs1_idx=5 reads busy=0, tag=0, val=0 immediately.
- Rename x5 tag 3 → next cycle busy=1, tag=3. Commit x5 tag 3 res 0x1234 → next cycle busy=0, val=0x1234.
- Stale commit: rename x7 tag 2, then rename x7 tag 4. Commit x7 tag 2 res 0xAA → val=0xAA, busy=1, tag=4. Commit tag 4 res 0xBB → busy=0, val=0xBB.
- Same cycle: commit x9 tag 6 res 0x55 while renaming x9 tag 8 → val=0x55, busy=1, tag=8.
- Flush: x3 busy tag 1, x4 busy tag 2, flush together with commit x3 tag 1 res 0x77 and rename x6 tag 5 → x3 val=0x77; all busy=0; x6 not busy.
- Bypass (with REG_COMMIT_BYPASS_EN): x10 busy tag 9, commit x10 tag 9 res 0xDEAD, rs2_idx=10 → same cycle busy=0, val=0xDEAD. Without the macro → busy=1, tag=9. Writes to x0 → x0 always reads 0.
